ps2_host_transmitter: RTL and testbench

PS2_HOST_TRANSMITTER -- requirements
Module: ps2_host_transmitter

---
 rtl/ps2_host_transmitter.sv | 172 +++++++++++++++++
 tb/tb_ps2_host_transmitter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a request-to-send,
// shifts a command byte out on device clock falling edges, then checks the ACK.
module ps2_host_transmitter #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 375000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    SEND,
    ACK,
    RELEASE
  } state_t;

  state_t        state;
  logic [7:0]    data_q;
  logic [3:0]    bit_idx;
  logic [IW-1:0] inh_cnt;
  logic [WW-1:0] wd_cnt;
  logic          ack_lvl;
  logic          acked;

  logic clk_s1, clk_s2, clk_s3;
  logic dat_s1, dat_s2;
  logic fall;

  // Line level for frame position idx: data[0..7], odd parity, then stop.
  function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] idx);
    if (idx < 4'd8)       return d[idx[2:0]];
    else if (idx == 4'd8) return ~^d;
    else                  return 1'b1;
  endfunction

  // Two-flop synchronizers plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= PS2_DAT;
      dat_s2 <= dat_s1;
    end
  end

  assign fall    = clk_s3 & ~clk_s2;
  assign tx_busy = ~tx_ready;

  // Transfer state machine with registered line enables and status pulses.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      data_q     <= '0;
      bit_idx    <= '0;
      inh_cnt    <= '0;
      wd_cnt     <= '0;
      ack_lvl    <= 1'b0;
      acked      <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            data_q     <= tx_data;
            state      <= INHIBIT;
            tx_ready   <= 1'b0;
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= (INHIBIT_CYCLES == 1);
            inh_cnt    <= '0;
            acked      <= 1'b0;
          end
        end
        INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            state      <= REQUEST;
            ps2_clk_oe <= 1'b0;
            wd_cnt     <= '0;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
            if (inh_cnt == INH_PRE) ps2_dat_oe <= 1'b1;
          end
        end
        default: begin
          if (!fall && wd_cnt == WD_LAST) begin
            // A NACK already reported its error; only an acked transfer still owes a pulse.
            state      <= IDLE;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_ready   <= 1'b1;
            tx_error   <= (state != RELEASE) || acked;
            acked      <= 1'b0;
            bit_idx    <= '0;
            wd_cnt     <= '0;
          end else begin
            wd_cnt <= fall ? '0 : wd_cnt + 1'b1;
            case (state)
              REQUEST: begin
                if (fall) begin
                  state      <= SEND;
                  bit_idx    <= '0;
                  ps2_dat_oe <= ~data_q[0];
                end
              end
              SEND: begin
                if (fall) begin
                  if (bit_idx == 4'd9) begin
                    state      <= ACK;
                    ack_lvl    <= dat_s2;
                    ps2_dat_oe <= 1'b0;
                  end else begin
                    bit_idx    <= bit_idx + 4'd1;
                    ps2_dat_oe <= ~frame_bit(data_q, bit_idx + 4'd1);
                  end
                end
              end
              ACK: begin
                state  <= RELEASE;
                wd_cnt <= '0;
                if (!ack_lvl) acked    <= 1'b1;
                else          tx_error <= 1'b1;
              end
              RELEASE: begin
                if (clk_s2 && dat_s2) begin
                  state    <= IDLE;
                  tx_ready <= 1'b1;
                  tx_done  <= acked;
                  acked    <= 1'b0;
                  bit_idx  <= '0;
                  wd_cnt   <= '0;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Scoreboard bench for ps2_host_transmitter with an open-drain PS/2 device model.
module tb_ps2_host_transmitter;

  localparam int unsigned INH  = 50;
  localparam int unsigned TMO  = 600;
  localparam int          HALF = 40;

  localparam int M_ACK   = 0;
  localparam int M_NACK  = 1;
  localparam int M_TMO   = 2;
  localparam int M_VALID = 3;
  localparam int M_RST   = 4;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       PS2_CLK, PS2_DAT;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_error;

  int checks = 0;
  int failures = 0;
  bit          exp_res[$];     // 1 = done expected, 0 = error expected
  logic [10:0] exp_frames[$];
  bit          exp_kind;

  assign PS2_CLK = ~(dev_clk_low | ps2_clk_oe);
  assign PS2_DAT = ~(dev_dat_low | ps2_dat_oe);

  ps2_host_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetN(resetN), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i + 1] = d[i];
    f[9]  = ($countones(d) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Result monitor: every done/error pulse must match the next expected outcome.
  always @(negedge clk) begin
    if (tx_done || tx_error) begin
      check("done_error_exclusive", tx_done && tx_error, 0);
      if (exp_res.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got done=%0d error=%0d required none", tx_done, tx_error);
      end else begin
        exp_kind = exp_res.pop_front();
        check("result_kind_done", tx_done, exp_kind);
      end
    end
  end

  task automatic reset_mid();
    resetN = 1'b0;
    #1;
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_dat_oe", ps2_dat_oe, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_ready", tx_ready, 1);
    check("post_rst_clk_oe", ps2_clk_oe, 0);
  endtask

  task automatic run_txn(input int mode, input logic [7:0] din);
    int          n;
    int          inh_n;
    int          both_n;
    logic [7:0]  d;
    logic [10:0] frame;
    bit          aborted;
    d = (mode == M_RST) ? (din & 8'hEF) : din;  // bit 4 = 0 keeps data driven low at reset time
    n = 0;
    while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
    check("ready_before_issue", tx_ready, 1);
    if (mode == M_ACK || mode == M_VALID) exp_res.push_back(1'b1);
    if (mode == M_NACK || mode == M_TMO)  exp_res.push_back(1'b0);
    if (mode == M_ACK || mode == M_NACK || mode == M_VALID) exp_frames.push_back(model_frame(d));

    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    inh_n  = 0;
    both_n = 0;
    while (ps2_clk_oe && inh_n < 10 * INH) begin
      inh_n++;
      if (ps2_dat_oe) both_n++;
      @(negedge clk);
    end
    check("inhibit_cycles", inh_n, INH);
    check("dat_low_in_last_inhibit", both_n, 1);
    check("start_bit_driven", ps2_dat_oe, 1);

    if (mode == M_TMO) begin
      n = 0;
      while (!tx_error && n < 2 * TMO) begin @(negedge clk); n++; end
      check("timeout_latency", n, TMO);
      check("timeout_clk_oe", ps2_clk_oe, 0);
      check("timeout_dat_oe", ps2_dat_oe, 0);
      check("timeout_ready", tx_ready, 1);
      repeat (2) @(negedge clk);
      check("result_pending", exp_res.size(), 0);
      return;
    end

    repeat (HALF) @(negedge clk);
    frame    = '0;
    frame[0] = PS2_DAT;
    aborted  = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      for (int c = 0; c < HALF; c++) begin
        if (mode == M_VALID && k == 3) begin
          tx_valid = (c == 5);
          if (c == 5) tx_data = ~d;
        end
        if (mode == M_RST && k == 5 && c == 10) begin
          reset_mid();
          aborted = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (aborted) break;
      if (k == 11 && mode == M_NACK) check("nack_waits_for_lines", tx_ready, 0);
      if (k <= 10) frame[k] = PS2_DAT;
      dev_clk_low = 1'b0;
      if (k == 10 && mode != M_NACK) dev_dat_low = 1'b1;
      if (k == 11) dev_dat_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    if (aborted) return;

    check("frame_bits", frame, exp_frames.pop_front());
    n = 0;
    while (!tx_ready && n < 500) begin @(negedge clk); n++; end
    check("return_to_idle", tx_ready, 1);
    check("idle_clk_oe", ps2_clk_oe, 0);
    check("idle_dat_oe", ps2_dat_oe, 0);
    repeat (2) @(negedge clk);
    check("result_pending", exp_res.size(), 0);
    if (mode == M_VALID) begin
      n = 0;
      repeat (200) begin
        @(negedge clk);
        if (ps2_clk_oe) n++;
      end
      check("no_second_transfer", n, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ready", tx_ready, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_dat_oe", ps2_dat_oe, 0);
    check("reset_done", tx_done, 0);
    check("reset_error", tx_error, 0);
    resetN = 1'b1;
    @(negedge clk);

    run_txn(M_ACK, 8'hED);
    run_txn(M_ACK, 8'h00);
    run_txn(M_ACK, 8'h01);
    run_txn(M_NACK, 8'($urandom));
    run_txn(M_TMO, 8'($urandom));
    run_txn(M_VALID, 8'($urandom));
    run_txn(M_RST, 8'($urandom));
    for (int i = 0; i < 10; i++) run_txn(int'($urandom_range(0, 4)), 8'($urandom));

    repeat (10) @(negedge clk);
    check("leftover_results", exp_res.size(), 0);
    check("leftover_frames", exp_frames.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running required finished");
    $fatal(1, "global timeout");
  end

endmodule
